uart_rx_module: RTL and testbench

UART_RX_MODULE -- requirements
Module: uart_rx_module

---
 rtl/uart_rx_module_if.sv | 42 ++++
 rtl/uart_rx_module.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_module.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_module_if.sv
// uart_rx_module_if: serial input, receive enable and received-byte outputs of
// uart_rx_module. Frame_Err_Sig and its modport entries exist only when the
// UART_RX_FRAME_CHECK_EN macro is defined.
interface uart_rx_module_if;
    logic       RX_Pin_In;
    logic       RX_En_Sig;
    logic       RX_Done_Sig;
    logic [7:0] RX_Data;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       Frame_Err_Sig;

    modport master (
        output RX_Pin_In,
        output RX_En_Sig,
        input  RX_Done_Sig,
        input  RX_Data,
        input  Frame_Err_Sig
    );

    modport slave (
        input  RX_Pin_In,
        input  RX_En_Sig,
        output RX_Done_Sig,
        output RX_Data,
        output Frame_Err_Sig
    );
`else
    modport master (
        output RX_Pin_In,
        output RX_En_Sig,
        input  RX_Done_Sig,
        input  RX_Data
    );

    modport slave (
        input  RX_Pin_In,
        input  RX_En_Sig,
        output RX_Done_Sig,
        output RX_Data
    );
`endif
endinterface

// File: rtl/uart_rx_module.sv
// uart_rx_module: 8N1 UART receiver. The serial line is synchronized, a falling
// edge in IDLE (with RX_En_Sig high) starts a frame, and every bit is sampled
// at mid-period using a 16-bit counter of BPS_DIV clocks per bit.
// Optional macro UART_RX_FRAME_CHECK_EN: check the stop bit, report a bad one
// on Frame_Err_Sig and suppress RX_Done_Sig for that frame.
module uart_rx_module #(
    parameter int BPS_DIV = 434
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_module_if.slave rx
);

    localparam logic [15:0] CNT_LAST = 16'(BPS_DIV - 1);
    // The counter reads 0 one cycle after the start edge is seen, so the
    // mid-bit point lands one count before BPS_DIV/2.
    localparam logic [15:0] CNT_MID  = 16'((BPS_DIV / 2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q,  edge_d;
    logic        h2l_q,   h2l_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q,  data_d;
    logic        done_q,  done_d;
`ifdef UART_RX_FRAME_CHECK_EN
    logic        err_q,   err_d;
`endif

    logic        line;
    logic        at_mid;
    logic        at_last;

    assign line    = sync2_q;
    assign at_mid  = (cnt_q == CNT_MID);
    assign at_last = (cnt_q == CNT_LAST);

    // Synchronizer, delayed copy and registered falling-edge detect of the pin.
    always_comb begin
        sync1_d = rx.RX_Pin_In;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        h2l_d   = edge_q & ~sync2_q;
    end

    // Synchronizer chain idles high so reset never fabricates a falling edge
    // from a high line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
            h2l_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            h2l_q   <= h2l_d;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only from IDLE, leave STOP at its mid-bit sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (h2l_q && rx.RX_En_Sig) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_mid && line) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_cnt_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_mid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath/output logic: bit timing, shifting, byte load and pulses.
    always_comb begin
        cnt_d     = at_last ? 16'd0 : (cnt_q + 16'd1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        err_d     = 1'b0;
`endif
        // Counter rests at 0 in IDLE and restarts on every state change.
        if ((state_q == IDLE) || (state_d != state_q)) begin
            cnt_d = 16'd0;
        end
        case (state_q)
            START: begin
                bit_cnt_d = 3'd0;
            end
            DATA: begin
                if (at_mid) begin
                    shift_d = {line, shift_q[7:1]};
                end
                if (at_last) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (at_mid) begin
`ifdef UART_RX_FRAME_CHECK_EN
                    if (line) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
`else
                    data_d = shift_q;
                    done_d = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; everything visible returns to zero under reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    // Frame error pulse register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rx.Frame_Err_Sig = err_q;
`endif

    assign rx.RX_Done_Sig = done_q;
    assign rx.RX_Data     = data_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module: directed and randomized frames for uart_rx_module at
// 16 clocks per bit, compared against a frame-level model of the receiver.
module tb_uart_rx_module;

    localparam int BPS = 16;
    localparam int LAT = 3 + 9 * BPS + BPS / 2 + 1;
`ifdef UART_RX_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   start_cyc;
    int   dbl_cnt;
    int   err_cnt;
    logic prev_done;
    logic b2b_seen;
    logic [7:0] exp_data;
    logic [7:0] done_data[$];
    int         done_cyc[$];

    uart_rx_module_if rx_if();

    uart_rx_module #(.BPS_DIV(BPS)) dut (
        .CLK (clk),
        .RST (rst),
        .rx  (rx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every done pulse with its data and cycle; count back-to-back pulses.
    always @(negedge clk) begin
        if (rx_if.RX_Done_Sig === 1'b1) begin
            done_data.push_back(rx_if.RX_Data);
            done_cyc.push_back(cyc);
        end
        if ((rx_if.RX_Done_Sig === 1'b1) && (prev_done === 1'b1)) dbl_cnt++;
        prev_done = rx_if.RX_Done_Sig;
`ifdef UART_RX_FRAME_CHECK_EN
        if (rx_if.Frame_Err_Sig === 1'b1) err_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial frame: start 0, eight data bits LSB first, then the given stop bit.
    task automatic drive_frame(input logic [7:0] b, input logic stop_b);
        logic [9:0] bits;
        bits = {stop_b, b, 1'b0};
        @(negedge clk);
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_if.RX_Pin_In = bits[i];
            repeat (BPS) @(negedge clk);
        end
        rx_if.RX_Pin_In = 1'b1;
    endtask

    // Send one frame and compare the outcome with the frame-level model.
    task automatic run_frame(input logic [7:0] b, input logic en, input logic stop_b, input string tag);
        int   n0;
        int   e0;
        logic exp_d;
        logic exp_e;
        n0 = done_data.size();
        e0 = err_cnt;
        rx_if.RX_En_Sig = en;
        drive_frame(b, stop_b);
        repeat (6) @(negedge clk);
        exp_d = en && (stop_b || !FCHK);
        exp_e = en && !stop_b && FCHK;
        check({tag, "_count"}, 32'(done_data.size() - n0), 32'(exp_d));
        if (exp_d) begin
            check({tag, "_data"}, 32'(done_data[$]), 32'(b));
            check({tag, "_latency"}, 32'(done_cyc[$] - start_cyc), 32'(LAT));
            exp_data = b;
        end
        check({tag, "_hold"}, 32'(rx_if.RX_Data), 32'(exp_data));
        check({tag, "_ferr"}, 32'(err_cnt - e0), 32'(exp_e));
    endtask

    initial begin
        int   n0;
        logic [7:0] rb;
        logic ren;
        logic rstop;

        checks    = 0;
        errors    = 0;
        dbl_cnt   = 0;
        err_cnt   = 0;
        prev_done = 1'b0;
        exp_data  = 8'h00;
        rst       = 1'b1;
        rx_if.RX_Pin_In = 1'b1;
        rx_if.RX_En_Sig = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_done", 32'(rx_if.RX_Done_Sig), 32'd0);
        check("reset_data", 32'(rx_if.RX_Data), 32'h00);
`ifdef UART_RX_FRAME_CHECK_EN
        check("reset_ferr", 32'(rx_if.Frame_Err_Sig), 32'd0);
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic reception and latency
        run_frame(8'h55, 1'b1, 1'b1, "rx55");

        // Disabled receiver ignores a frame
        run_frame(8'hA3, 1'b0, 1'b1, "dis_a3");
        repeat (4) @(negedge clk);

        // Short low glitch is a false start, then a real frame
        rx_if.RX_En_Sig = 1'b1;
        n0 = done_data.size();
        @(negedge clk);
        rx_if.RX_Pin_In = 1'b0;
        repeat (4) @(negedge clk);
        rx_if.RX_Pin_In = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", 32'(done_data.size() - n0), 32'd0);
        run_frame(8'h3C, 1'b1, 1'b1, "rx3c");

        // Back-to-back frames with the enable toggled after each done
        n0 = done_data.size();
        fork
            begin
                drive_frame(8'h00, 1'b1);
                drive_frame(8'hFF, 1'b1);
            end
            begin
                for (int f = 0; f < 2; f++) begin
                    b2b_seen = 1'b0;
                    for (int w = 0; (w < 400) && !b2b_seen; w++) begin
                        @(negedge clk);
                        b2b_seen = (rx_if.RX_Done_Sig === 1'b1);
                    end
                    check("b2b_done_seen", 32'(b2b_seen), 32'd1);
                    @(negedge clk);
                    rx_if.RX_En_Sig = 1'b0;
                    repeat (3) @(negedge clk);
                    rx_if.RX_En_Sig = 1'b1;
                end
            end
        join
        repeat (6) @(negedge clk);
        check("b2b_count", 32'(done_data.size() - n0), 32'd2);
        if (done_data.size() >= n0 + 2) begin
            check("b2b_first", 32'(done_data[n0]), 32'h00);
            check("b2b_second", 32'(done_data[n0 + 1]), 32'hFF);
        end
        exp_data = 8'hFF;
        check("b2b_hold", 32'(rx_if.RX_Data), 32'hFF);

        // Bad stop bit
        run_frame(8'h81, 1'b1, 1'b0, "badstop81");

        // Reset in the middle of a frame
        n0 = done_data.size();
        fork
            drive_frame(8'hF0, 1'b1);
            begin
                @(negedge clk);
                repeat (5 * BPS + 4) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rstmid_done", 32'(rx_if.RX_Done_Sig), 32'd0);
                check("rstmid_data", 32'(rx_if.RX_Data), 32'h00);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        exp_data = 8'h00;
        repeat (6) @(negedge clk);
        check("rstmid_count", 32'(done_data.size() - n0), 32'd0);
        run_frame(8'h0F, 1'b1, 1'b1, "after_rst0f");

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            rb    = 8'($urandom);
            ren   = ($urandom_range(0, 3) != 0);
            rstop = ($urandom_range(0, 3) != 0);
            run_frame(rb, ren, rstop, "rand");
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        check("no_double_done", 32'(dbl_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
